// File: rtl/rgb_to_yuv_encoder.sv
`timescale 1ns/1ps
// RGB -> YUV 4:2:2 encoder: reads interleaved RGB from SRAM, writes planar Y/U/V back.
// Groups of 4 pixels (6 read words) become 4 write words.
module rgb_to_yuv_encoder #(
    parameter int RGB_BASE = 146944,
    parameter int Y_BASE   = 0,
    parameter int U_BASE   = 38400,
    parameter int V_BASE   = 57600,
    parameter int PIXELS   = 76800
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        enc_start,
    output logic        enc_done,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic [4:0]  o_state
);
    typedef enum logic [4:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5,
        S_WAIT0, S_WAIT1, S_WAIT2, S_CONV0, S_CONV1, S_CONV2, S_CONV3,
        S_WR_Y0, S_WR_Y1, S_WR_U, S_WR_V, S_DONE
    } state_t;

    localparam logic [17:0] RGB_A    = 18'(RGB_BASE);
    localparam logic [17:0] Y_A      = 18'(Y_BASE);
    localparam logic [17:0] U_A      = 18'(U_BASE);
    localparam logic [17:0] V_A      = 18'(V_BASE);
    localparam logic [31:0] GRP_LAST = 32'(PIXELS / 4 - 1);

    state_t             r_state, w_next;
    logic [17:0]        r_rgb_ptr, r_y_ptr, r_u_ptr, r_v_ptr, w_rgb_cur;
    logic [31:0]        r_grp;
    logic [15:0]        r_w [0:5];
    logic [7:0]         r_y [0:3];
    logic [7:0]         r_u [0:3];
    logic [7:0]         r_v [0:3];
    logic [7:0]         w_pr, w_pg, w_pb;
    logic signed [31:0] w_r, w_g, w_b, w_y_acc, w_u_acc, w_v_acc;
    logic [17:0]        w_addr_d;
    logic [15:0]        w_data_d;
    logic               w_we_n_d, w_done_d;

    function automatic logic [7:0] clip8(input logic signed [31:0] acc);
        logic signed [31:0] s;
        s = acc >>> 16;
        if (s < 0)
            return 8'd0;
        else if (s > 32'sd255)
            return 8'hFF;
        else
            return s[7:0];
    endfunction

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

    assign o_state   = r_state;
    assign w_rgb_cur = (r_state == S_IDLE) ? RGB_A : r_rgb_ptr;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (enc_start) w_next = S_RD0;
            S_WR_V:  w_next = (r_grp == GRP_LAST) ? S_DONE : S_RD0;
            S_DONE:  w_next = S_IDLE;
            default: w_next = state_t'(r_state + 5'd1);
        endcase
    end

    // Outputs are computed for the state being entered, so they are registered and valid throughout it.
    always_comb begin
        w_addr_d = SRAM_address;
        w_data_d = SRAM_write_data;
        w_we_n_d = 1'b1;
        w_done_d = 1'b0;
        case (w_next)
            S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5: w_addr_d = w_rgb_cur;
            S_WR_Y0: begin
                w_addr_d = r_y_ptr;
                w_data_d = {r_y[0], r_y[1]};
                w_we_n_d = 1'b0;
            end
            S_WR_Y1: begin
                w_addr_d = r_y_ptr;
                w_data_d = {r_y[2], r_y[3]};
                w_we_n_d = 1'b0;
            end
            S_WR_U: begin
                w_addr_d = r_u_ptr;
                w_data_d = {avg8(r_u[0], r_u[1]), avg8(r_u[2], r_u[3])};
                w_we_n_d = 1'b0;
            end
            S_WR_V: begin
                w_addr_d = r_v_ptr;
                w_data_d = {avg8(r_v[0], r_v[1]), avg8(r_v[2], r_v[3])};
                w_we_n_d = 1'b0;
            end
            S_DONE:  w_done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            SRAM_address    <= RGB_A;
            SRAM_write_data <= 16'd0;
            SRAM_we_n       <= 1'b1;
            enc_done        <= 1'b0;
            r_rgb_ptr       <= RGB_A;
            r_y_ptr         <= Y_A;
            r_u_ptr         <= U_A;
            r_v_ptr         <= V_A;
            r_grp           <= 32'd0;
        end else begin
            SRAM_address    <= w_addr_d;
            SRAM_write_data <= w_data_d;
            SRAM_we_n       <= w_we_n_d;
            enc_done        <= w_done_d;
            if (r_state == S_IDLE && w_next == S_RD0) begin
                r_y_ptr <= Y_A;
                r_u_ptr <= U_A;
                r_v_ptr <= V_A;
                r_grp   <= 32'd0;
            end
            if (r_state == S_WR_V)
                r_grp <= r_grp + 32'd1;
            case (w_next)
                S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5: r_rgb_ptr <= w_rgb_cur + 18'd1;
                S_WR_Y0, S_WR_Y1: r_y_ptr <= r_y_ptr + 18'd1;
                S_WR_U:  r_u_ptr <= r_u_ptr + 18'd1;
                S_WR_V:  r_v_ptr <= r_v_ptr + 18'd1;
                default: ;
            endcase
        end
    end

    // Read data arrives three states after its address: RD3..WAIT2 capture words 0..5.
    always_ff @(posedge CLOCK_50_I) begin
        case (r_state)
            S_RD3:   r_w[0] <= SRAM_read_data;
            S_RD4:   r_w[1] <= SRAM_read_data;
            S_RD5:   r_w[2] <= SRAM_read_data;
            S_WAIT0: r_w[3] <= SRAM_read_data;
            S_WAIT1: r_w[4] <= SRAM_read_data;
            S_WAIT2: r_w[5] <= SRAM_read_data;
            default: ;
        endcase
    end

    always_comb begin
        w_pr = r_w[0][15:8];
        w_pg = r_w[0][7:0];
        w_pb = r_w[1][15:8];
        case (r_state)
            S_CONV1: begin w_pr = r_w[1][7:0];  w_pg = r_w[2][15:8]; w_pb = r_w[2][7:0];  end
            S_CONV2: begin w_pr = r_w[3][15:8]; w_pg = r_w[3][7:0];  w_pb = r_w[4][15:8]; end
            S_CONV3: begin w_pr = r_w[4][7:0];  w_pg = r_w[5][15:8]; w_pb = r_w[5][7:0];  end
            default: ;
        endcase
    end

    assign w_r = $signed({24'd0, w_pr});
    assign w_g = $signed({24'd0, w_pg});
    assign w_b = $signed({24'd0, w_pb});
    assign w_y_acc = 32'sd16843 * w_r + 32'sd33030 * w_g + 32'sd6423 * w_b + 32'sd1081344;
    assign w_u_acc = 32'sd28770 * w_b - 32'sd9699 * w_r - 32'sd19071 * w_g + 32'sd8421376;
    assign w_v_acc = 32'sd28770 * w_r - 32'sd24117 * w_g - 32'sd4653 * w_b + 32'sd8421376;

    always_ff @(posedge CLOCK_50_I) begin
        case (r_state)
            S_CONV0: begin r_y[0] <= clip8(w_y_acc); r_u[0] <= clip8(w_u_acc); r_v[0] <= clip8(w_v_acc); end
            S_CONV1: begin r_y[1] <= clip8(w_y_acc); r_u[1] <= clip8(w_u_acc); r_v[1] <= clip8(w_v_acc); end
            S_CONV2: begin r_y[2] <= clip8(w_y_acc); r_u[2] <= clip8(w_u_acc); r_v[2] <= clip8(w_v_acc); end
            S_CONV3: begin r_y[3] <= clip8(w_y_acc); r_u[3] <= clip8(w_u_acc); r_v[3] <= clip8(w_v_acc); end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
`timescale 1ns/1ps
// Bench for rgb_to_yuv_encoder with PIXELS=8: SRAM model with 3-edge read latency,
// scoreboard queues for expected reads and writes.
module tb_rgb_to_yuv_encoder;
    localparam int RGB_BASE = 146944;
    localparam int Y_BASE   = 0;
    localparam int U_BASE   = 38400;
    localparam int V_BASE   = 57600;
    localparam int PIXELS   = 8;
    localparam int NWORDS   = PIXELS * 3 / 2;

    logic        clk;
    logic        resetn;
    logic        enc_start;
    logic        enc_done;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_we_n;
    logic [15:0] sram_rdata;
    logic [4:0]  dut_state;

    logic [15:0] rgb_mem [0:NWORDS-1];
    logic [17:0] a_neg;
    logic [15:0] p1, p2;
    logic [33:0] exp_q [$];
    logic [17:0] rd_q [$];
    int          checks = 0;
    int          errors = 0;

    rgb_to_yuv_encoder #(
        .RGB_BASE(RGB_BASE), .Y_BASE(Y_BASE), .U_BASE(U_BASE), .V_BASE(V_BASE), .PIXELS(PIXELS)
    ) dut (
        .CLOCK_50_I(clk),
        .resetn(resetn),
        .enc_start(enc_start),
        .enc_done(enc_done),
        .SRAM_address(sram_addr),
        .SRAM_write_data(sram_wdata),
        .SRAM_we_n(sram_we_n),
        .SRAM_read_data(sram_rdata),
        .o_state(dut_state)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SRAM read model: data for an address appears three rising edges after it is driven.
    always @(negedge clk) a_neg <= sram_addr;
    always @(posedge clk) begin
        if ((int'(a_neg) >= RGB_BASE) && (int'(a_neg) < RGB_BASE + NWORDS))
            p1 <= rgb_mem[int'(a_neg) - RGB_BASE];
        else
            p1 <= 16'h0000;
        p2         <= p1;
        sram_rdata <= p2;
    end

    // Bus monitor: read addresses in order, writes only from write states, write contents.
    always @(negedge clk) begin
        if (resetn) begin
            if (dut_state >= 5'd1 && dut_state <= 5'd6) begin
                if (rd_q.size() == 0)
                    check("unexpected_read", 64'(sram_addr), 64'h3FFFF);
                else
                    check("read_addr", 64'(sram_addr), 64'(rd_q.pop_front()));
            end
            if (sram_we_n == 1'b0) begin
                check("write_in_wr_state", 64'(dut_state >= 5'd14 && dut_state <= 5'd17), 64'd1);
                if (exp_q.size() == 0)
                    check("unexpected_write", 64'({sram_addr, sram_wdata}), 64'h3_FFFF_FFFF);
                else
                    check("write_addr_data", 64'({sram_addr, sram_wdata}), 64'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [7:0] clipm(input int acc);
        int s;
        s = acc >>> 16;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    function automatic logic [7:0] avgm(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'(a) + int'(b) + 1;
        return 8'(s >> 1);
    endfunction

    function automatic int byte_at(input int n);
        logic [15:0] w;
        w = rgb_mem[n / 2];
        return (n % 2 == 0) ? int'(w[15:8]) : int'(w[7:0]);
    endfunction

    task automatic push_reads();
        for (int i = 0; i < NWORDS; i++) rd_q.push_back(18'(RGB_BASE + i));
    endtask

    task automatic push_model();
        logic [7:0] y [4];
        logic [7:0] u [4];
        logic [7:0] v [4];
        int r, g, b;
        for (int grp = 0; grp < PIXELS / 4; grp++) begin
            for (int k = 0; k < 4; k++) begin
                r = byte_at(grp * 12 + 3 * k);
                g = byte_at(grp * 12 + 3 * k + 1);
                b = byte_at(grp * 12 + 3 * k + 2);
                y[k] = clipm(16843 * r + 33030 * g + 6423 * b + (16 << 16) + 32768);
                u[k] = clipm(-9699 * r - 19071 * g + 28770 * b + (128 << 16) + 32768);
                v[k] = clipm(28770 * r - 24117 * g - 4653 * b + (128 << 16) + 32768);
            end
            exp_q.push_back({18'(Y_BASE + 2 * grp), y[0], y[1]});
            exp_q.push_back({18'(Y_BASE + 2 * grp + 1), y[2], y[3]});
            exp_q.push_back({18'(U_BASE + grp), avgm(u[0], u[1]), avgm(u[2], u[3])});
            exp_q.push_back({18'(V_BASE + grp), avgm(v[0], v[1]), avgm(v[2], v[3])});
        end
    endtask

    // One full run; with hold=1 enc_start stays high until the encoder is back in idle.
    task automatic run_one(input bit hold);
        int done_at, pulses, idle_seen;
        logic [4:0] st_after;
        done_at = 0; pulses = 0; idle_seen = 0; st_after = 5'h1F;
        @(negedge clk);
        enc_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (!hold && k == 1) enc_start = 1'b0;
            if (enc_done) begin
                pulses++;
                if (done_at == 0) done_at = k;
            end
            if (k < 35 && dut_state == 5'd0) idle_seen++;
            if (k == 36) st_after = dut_state;
        end
        enc_start = 1'b0;
        check("done_cycle", 64'(done_at), 64'd35);
        check("done_pulses", 64'(pulses), 64'd1);
        check("busy_never_idle", 64'(idle_seen), 64'd0);
        check("idle_after_done", 64'(st_after), 64'd0);
        check("writes_left", 64'(exp_q.size()), 64'd0);
        check("reads_left", 64'(rd_q.size()), 64'd0);
        if (hold) begin
            @(negedge clk);
            check("no_restart", 64'(dut_state), 64'd0);
        end
    endtask

    initial begin
        int found;
        resetn = 1'b0;
        enc_start = 1'b0;
        #25;
        check("rst_state", 64'(dut_state), 64'd0);
        check("rst_addr", 64'(sram_addr), 64'(RGB_BASE));
        check("rst_wdata", 64'(sram_wdata), 64'd0);
        check("rst_we_n", 64'(sram_we_n), 64'd1);
        check("rst_done", 64'(enc_done), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Group 0: red then three black pixels; group 1: white.
        rgb_mem[0] = 16'hFF00;
        for (int i = 1; i < 6; i++) rgb_mem[i] = 16'h0000;
        for (int i = 6; i < 12; i++) rgb_mem[i] = 16'hFFFF;
        push_reads();
        exp_q.push_back({18'd0, 16'h5210});
        exp_q.push_back({18'd1, 16'h1010});
        exp_q.push_back({18'd38400, 16'h6D80});
        exp_q.push_back({18'd57600, 16'hB880});
        exp_q.push_back({18'd2, 16'hEBEB});
        exp_q.push_back({18'd3, 16'hEBEB});
        exp_q.push_back({18'd38401, 16'h8080});
        exp_q.push_back({18'd57601, 16'h8080});
        run_one(1'b0);

        // Distinct word values so any misplaced capture changes a result.
        for (int i = 0; i < NWORDS; i++) rgb_mem[i] = {4'(i), 12'($urandom_range(0, 4095))};
        push_reads();
        push_model();
        run_one(1'b0);

        for (int i = 0; i < NWORDS; i++) rgb_mem[i] = 16'($urandom_range(0, 65535));
        push_reads();
        push_model();
        run_one(1'b0);

        // Reset during the second conversion cycle of the first group.
        push_reads();
        push_model();
        @(negedge clk);
        enc_start = 1'b1;
        @(negedge clk);
        enc_start = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            if (dut_state == 5'd11) found = 1;
            else @(negedge clk);
        end
        check("conv1_reached", 64'(found), 64'd1);
        resetn = 1'b0;
        #1;
        check("abort_we_n", 64'(sram_we_n), 64'd1);
        check("abort_state", 64'(dut_state), 64'd0);
        check("abort_done", 64'(enc_done), 64'd0);
        exp_q.delete();
        rd_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        push_reads();
        push_model();
        run_one(1'b0);

        // enc_start held high for a whole run.
        for (int i = 0; i < NWORDS; i++) rgb_mem[i] = 16'($urandom_range(0, 65535));
        push_reads();
        push_model();
        run_one(1'b1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
